// File: rtl/alu_rr_sched.sv
// alu_rr_sched: round-robin arbiter sharing one registered 4-bit ALU between two requesters
module alu_rr_sched #(
  parameter int ALU_LAT = 1,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_a,
  input  logic [3:0]       req0_b,
  input  logic [2:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_a,
  input  logic [3:0]       req1_b,
  input  logic [2:0]       req1_op,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [2:0]       alu_op,
  input  logic [7:0]       alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [7:0]       rsp_data,
  output logic             busy,
  output logic [CNT_W-1:0] done_cnt
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t     r_state;
  logic       r_prio;
  logic [2:0] r_cnt;
  logic       w_any;
  logic       w_gnt;
  logic       w_idle;
  assign w_idle     = r_state == IDLE;
  assign w_any      = req0_valid | req1_valid;
  assign w_gnt      = (req0_valid & req1_valid) ? r_prio : req1_valid;
  assign req0_ready = w_idle & req0_valid & ~w_gnt;
  assign req1_ready = w_idle & req1_valid & w_gnt;
  assign busy       = ~w_idle;
  // The wait counter runs ALU_LAT cycles to zero; the result is sampled on the edge after that.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_prio    <= 1'b0;
      r_cnt     <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      done_cnt  <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_any) begin
          alu_a   <= w_gnt ? req1_a : req0_a;
          alu_b   <= w_gnt ? req1_b : req0_b;
          alu_op  <= w_gnt ? req1_op : req0_op;
          rsp_id  <= w_gnt;
          r_cnt   <= 3'(ALU_LAT);
          r_state <= EXEC;
        end
        EXEC: if (r_cnt == 3'd0) begin
          rsp_data  <= alu_result;
          rsp_valid <= 1'b1;
          r_state   <= RESP;
        end else begin
          r_cnt <= r_cnt - 3'd1;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          done_cnt  <= done_cnt + CNT_W'(1);
          r_prio    <= ~rsp_id;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_rr_sched.sv
// tb_alu_rr_sched: randomized and directed checks of alu_rr_sched against a transaction-level model
module tb_alu_rr_sched;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  logic       req0_valid = 0, req1_valid = 0, rsp_ready = 0;
  logic [3:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic [2:0] req0_op = 0, req1_op = 0;
  logic       req0_ready, req1_ready, rsp_valid, rsp_id, busy;
  logic [3:0] alu_a, alu_b;
  logic [2:0] alu_op;
  logic [7:0] alu_result, rsp_data, done_cnt;
  logic       v3 = 0, rr3 = 0, z1 = 0;
  logic [3:0] a3 = 0, b3 = 0, z4 = 0;
  logic [2:0] op3 = 0, z3 = 0;
  logic       r0r3, r1r3, rv3, rid3, busy3;
  logic [3:0] alu_a3, alu_b3;
  logic [2:0] alu_op3;
  logic [7:0] alu_res3, rd3;
  logic [1:0] dc3;
  logic [7:0] p3 [3];
  int n_vec = 0;
  int n_err = 0;
  alu_rr_sched #(.ALU_LAT(1), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .busy(busy), .done_cnt(done_cnt));
  alu_rr_sched #(.ALU_LAT(3), .CNT_W(2)) u_dut3 (
    .clk(clk), .rst(rst),
    .req0_valid(v3), .req0_ready(r0r3), .req0_a(a3), .req0_b(b3), .req0_op(op3),
    .req1_valid(z1), .req1_ready(r1r3), .req1_a(z4), .req1_b(z4), .req1_op(z3),
    .alu_a(alu_a3), .alu_b(alu_b3), .alu_op(alu_op3), .alu_result(alu_res3),
    .rsp_valid(rv3), .rsp_ready(rr3), .rsp_id(rid3), .rsp_data(rd3),
    .busy(busy3), .done_cnt(dc3));
  function automatic logic [7:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    logic [7:0] x, y;
    x = {4'b0, a};
    y = {4'b0, b};
    case (op)
      3'd0: return x + y;
      3'd1: return x - y;
      3'd2: return x & y;
      3'd3: return x | y;
      3'd4: return x ^ y;
      3'd5: return x >> b;
      3'd6: return x << b;
      default: return {7'b0, a > b};
    endcase
  endfunction
  // Registered ALU stand-ins sharing rst: latency 1 for u_dut, latency 3 for u_dut3.
  always @(posedge clk) begin
    alu_result <= rst ? 8'h00 : alu_f(alu_a, alu_b, alu_op);
    p3[0] <= rst ? 8'h00 : alu_f(alu_a3, alu_b3, alu_op3);
    p3[1] <= rst ? 8'h00 : p3[0];
    p3[2] <= rst ? 8'h00 : p3[1];
  end
  assign alu_res3 = p3[2];
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst = 1; req0_valid = 0; req1_valid = 0; v3 = 0;
    tick;
    rst = 0;
  endtask
  task automatic test_reset;
    rst = 1; req0_valid = 0; req1_valid = 0; v3 = 0;
    tick;
    n_vec++;
    if ({busy, rsp_valid, rsp_id, rsp_data, done_cnt} !== 19'd0) begin
      n_err++; $display("FAIL reset_status got %h exp 0", {busy, rsp_valid, rsp_id, rsp_data, done_cnt});
    end
    n_vec++;
    if ({alu_a, alu_b, alu_op, req0_ready, req1_ready} !== 13'd0) begin
      n_err++; $display("FAIL reset_alu_ready got %h exp 0", {alu_a, alu_b, alu_op, req0_ready, req1_ready});
    end
    n_vec++;
    if ({busy3, rv3, dc3, alu_a3} !== 8'd0) begin
      n_err++; $display("FAIL reset_dut3 got %h exp 0", {busy3, rv3, dc3, alu_a3});
    end
    rst = 0;
  endtask
  task automatic test_single;
    do_reset;
    rsp_ready = 1; req0_a = 4'h9; req0_b = 4'h8; req0_op = 3'd0; req0_valid = 1;
    #1;
    n_vec++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_err++; $display("FAIL single_ready got %b exp 10", {req0_ready, req1_ready});
    end
    tick;
    req0_valid = 0;
    #1;
    n_vec++;
    if ({busy, rsp_valid, req0_ready, alu_a, alu_b, alu_op} !== {3'b100, 4'h9, 4'h8, 3'd0}) begin
      n_err++; $display("FAIL single_grant got %h exp %h", {busy, rsp_valid, req0_ready, alu_a, alu_b, alu_op}, {3'b100, 4'h9, 4'h8, 3'd0});
    end
    tick;
    n_vec++;
    if (rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL single_early got %b exp 0", rsp_valid);
    end
    tick;
    n_vec++;
    if ({rsp_valid, rsp_id, rsp_data} !== {2'b10, 8'h11}) begin
      n_err++; $display("FAIL single_rsp got %h exp %h", {rsp_valid, rsp_id, rsp_data}, {2'b10, 8'h11});
    end
    tick;
    n_vec++;
    if ({done_cnt, rsp_valid, busy} !== {8'd1, 2'b00}) begin
      n_err++; $display("FAIL single_done got %h exp %h", {done_cnt, rsp_valid, busy}, {8'd1, 2'b00});
    end
  endtask
  task automatic test_contention;
    do_reset;
    rsp_ready = 1;
    req0_a = 4'h3; req0_b = 4'h5; req0_op = 3'd1; req0_valid = 1;
    req1_a = 4'hF; req1_b = 4'h3; req1_op = 3'd6; req1_valid = 1;
    #1;
    n_vec++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_err++; $display("FAIL cont_first_grant got %b exp 10", {req0_ready, req1_ready});
    end
    repeat (3) tick;
    n_vec++;
    if ({rsp_valid, rsp_id, rsp_data} !== {2'b10, 8'hFE}) begin
      n_err++; $display("FAIL cont_rsp0 got %h exp %h", {rsp_valid, rsp_id, rsp_data}, {2'b10, 8'hFE});
    end
    tick;
    n_vec++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      n_err++; $display("FAIL cont_second_grant got %b exp 01", {req0_ready, req1_ready});
    end
    repeat (3) tick;
    n_vec++;
    if ({rsp_valid, rsp_id, rsp_data} !== {2'b11, 8'h78}) begin
      n_err++; $display("FAIL cont_rsp1 got %h exp %h", {rsp_valid, rsp_id, rsp_data}, {2'b11, 8'h78});
    end
    tick;
    n_vec++;
    if ({req0_ready, req1_ready, done_cnt} !== {2'b10, 8'd2}) begin
      n_err++; $display("FAIL cont_third_grant got %h exp %h", {req0_ready, req1_ready, done_cnt}, {2'b10, 8'd2});
    end
    req0_valid = 0; req1_valid = 0;
  endtask
  task automatic test_back_pressure;
    do_reset;
    rsp_ready = 0;
    req1_a = 4'h7; req1_b = 4'h2; req1_op = 3'd7; req1_valid = 1;
    #1;
    n_vec++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      n_err++; $display("FAIL bp_grant got %b exp 01", {req0_ready, req1_ready});
    end
    tick;
    req1_valid = 0;
    req0_a = 4'h1; req0_b = 4'h1; req0_op = 3'd0; req0_valid = 1;
    tick;
    tick;
    for (int k = 0; k < 5; k++) begin
      n_vec++;
      if ({rsp_valid, rsp_id, rsp_data, req0_ready, done_cnt} !== {2'b11, 8'h01, 1'b0, 8'd0}) begin
        n_err++; $display("FAIL bp_hold cycle %0d got %h exp %h", k, {rsp_valid, rsp_id, rsp_data, req0_ready, done_cnt}, {2'b11, 8'h01, 1'b0, 8'd0});
      end
      tick;
    end
    rsp_ready = 1; req0_valid = 0;
    tick;
    n_vec++;
    if ({done_cnt, rsp_valid, busy} !== {8'd1, 2'b00}) begin
      n_err++; $display("FAIL bp_release got %h exp %h", {done_cnt, rsp_valid, busy}, {8'd1, 2'b00});
    end
  endtask
  // Transaction model: ph=0 idle, ph>0 edges left before the response, ph=-1 response pending.
  task automatic test_random(input int n);
    int         ph;
    logic       prio, eid, g;
    logic [7:0] edata, ecnt;
    logic [3:0] sa [2], sb [2];
    logic [2:0] so [2];
    logic       sv [2];
    do_reset;
    ph = 0; prio = 0; eid = 0; edata = 0; ecnt = 0;
    for (int i = 0; i < 2; i++) begin sv[i] = 0; sa[i] = 0; sb[i] = 0; so[i] = 0; end
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < 2; i++)
        if (!sv[i] && $urandom_range(0, 2) != 0) begin
          sv[i] = 1; sa[i] = 4'($urandom); sb[i] = 4'($urandom); so[i] = 3'($urandom);
        end
      req0_valid = sv[0]; req0_a = sa[0]; req0_b = sb[0]; req0_op = so[0];
      req1_valid = sv[1]; req1_a = sa[1]; req1_b = sb[1]; req1_op = so[1];
      rsp_ready = $urandom_range(0, 3) != 0;
      #1;
      g = (sv[0] && sv[1]) ? prio : sv[1];
      n_vec++;
      if ({req0_ready, req1_ready} !== ((ph == 0 && (sv[0] || sv[1])) ? (g ? 2'b01 : 2'b10) : 2'b00)) begin
        n_err++; $display("FAIL rand_ready cycle %0d got %b ph %0d v %b%b prio %b", k, {req0_ready, req1_ready}, ph, sv[1], sv[0], prio);
      end
      n_vec++;
      if ({rsp_valid, busy, done_cnt} !== {ph == -1, ph != 0, ecnt}) begin
        n_err++; $display("FAIL rand_status cycle %0d got %h exp %h", k, {rsp_valid, busy, done_cnt}, {ph == -1, ph != 0, ecnt});
      end
      if (ph == -1) begin
        n_vec++;
        if ({rsp_id, rsp_data} !== {eid, edata}) begin
          n_err++; $display("FAIL rand_rsp cycle %0d got %h exp %h", k, {rsp_id, rsp_data}, {eid, edata});
        end
      end
      if (ph == 0 && (sv[0] || sv[1])) begin
        eid = g; edata = alu_f(sa[g], sb[g], so[g]); sv[g] = 0; ph = 2;
      end else if (ph > 0) begin
        ph = (ph == 1) ? -1 : ph - 1;
      end else if (ph == -1 && rsp_ready) begin
        ecnt++; prio = ~eid; ph = 0;
      end
      tick;
    end
    req0_valid = 0; req1_valid = 0; rsp_ready = 1;
    repeat (6) tick;
  endtask
  task automatic test_reset_mid_op;
    do_reset;
    rsp_ready = 1;
    req0_a = 4'h1; req0_b = 4'h2; req0_op = 3'd0; req0_valid = 1;
    tick;
    req0_valid = 0;
    repeat (3) tick;
    req0_valid = 1;
    tick;
    req0_valid = 0;
    n_vec++;
    if ({busy, done_cnt} !== {1'b1, 8'd1}) begin
      n_err++; $display("FAIL mid_setup got %h exp %h", {busy, done_cnt}, {1'b1, 8'd1});
    end
    rst = 1;
    tick;
    rst = 0;
    n_vec++;
    if ({busy, rsp_valid, done_cnt, alu_a} !== 14'd0) begin
      n_err++; $display("FAIL mid_reset got %h exp 0", {busy, rsp_valid, done_cnt, alu_a});
    end
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if (rsp_valid !== 1'b0) begin
        n_err++; $display("FAIL mid_no_rsp cycle %0d got %b exp 0", k, rsp_valid);
      end
      tick;
    end
    req0_valid = 1; req1_valid = 1;
    #1;
    n_vec++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_err++; $display("FAIL mid_prio got %b exp 10", {req0_ready, req1_ready});
    end
    req0_valid = 0; req1_valid = 0;
    tick;
  endtask
  task automatic test_latency3;
    do_reset;
    rr3 = 1; a3 = 4'hA; b3 = 4'h5; op3 = 3'd4; v3 = 1;
    #1;
    n_vec++;
    if (r0r3 !== 1'b1) begin
      n_err++; $display("FAIL lat3_ready got %b exp 1", r0r3);
    end
    tick;
    v3 = 0;
    for (int k = 1; k <= 3; k++) begin
      tick;
      n_vec++;
      if (rv3 !== 1'b0) begin
        n_err++; $display("FAIL lat3_early cycle %0d got %b exp 0", k, rv3);
      end
    end
    tick;
    n_vec++;
    if ({rv3, rid3, rd3} !== {2'b10, 8'h0F}) begin
      n_err++; $display("FAIL lat3_rsp got %h exp %h", {rv3, rid3, rd3}, {2'b10, 8'h0F});
    end
    tick;
    n_vec++;
    if (dc3 !== 2'd1) begin
      n_err++; $display("FAIL lat3_done got %0d exp 1", dc3);
    end
  endtask
  task automatic test_wrap;
    logic [7:0] exp;
    int w;
    do_reset;
    rr3 = 1;
    for (int k = 0; k < 5; k++) begin
      a3 = 4'($urandom); b3 = 4'($urandom); op3 = 3'($urandom);
      exp = alu_f(a3, b3, op3);
      v3 = 1;
      tick;
      v3 = 0;
      w = 0;
      while (rv3 !== 1'b1 && w < 20) begin tick; w++; end
      n_vec++;
      if ({rv3, rd3} !== {1'b1, exp}) begin
        n_err++; $display("FAIL wrap_rsp op %0d got %h exp %h waited %0d", k, {rv3, rd3}, {1'b1, exp}, w);
      end
      tick;
      n_vec++;
      if (dc3 !== 2'(k + 1)) begin
        n_err++; $display("FAIL wrap_cnt op %0d got %0d exp %0d", k, dc3, 2'(k + 1));
      end
    end
  endtask
  initial begin
    test_reset;
    test_single;
    test_contention;
    test_back_pressure;
    test_random(400);
    test_reset_mid_op;
    test_latency3;
    test_wrap;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog timeout after %0d vectors", n_vec);
    $fatal(1);
  end
endmodule
